i2c_master_ctrl: RTL

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

---
 rtl/i2c_master_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C master (7-bit address, one write or read byte)
module i2c_master_ctrl #(
  parameter int DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       sclk,
  inout  wire        sda
);
  typedef enum logic [2:0] {IDLE, START, ADDR, ACK1, DATA, ACK2, STOP} state_t;
  state_t st_q, st_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0] ph_q, ph_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] ar_q, ar_d, wd_q, wd_d, rx_q, rx_d, rdata_q, rdata_d;
  logic nf_q, nf_d, busy_q, busy_d, done_q, done_d, nack_q, nack_d;
  logic sclk_q, sclk_d, low_q, low_d;
  logic sda_in, wrap, last, smp, txb;
  assign sda_in = sda;
  assign sda = low_q ? 1'b0 : 1'bz;
  assign rdata = rdata_q;
  assign busy = busy_q;
  assign done = done_q;
  assign nack = nack_q;
  assign sclk = sclk_q;
  assign wrap = cnt_q == 16'(DIV - 1);
  assign last = ph_q == 2'd2;
  assign smp = wrap && ph_q == 2'd1;
  // Next-state logic; bus outputs are derived from the next state so they register in step with it
  always_comb begin
    st_d = st_q;
    ph_d = ph_q;
    bit_d = bit_q;
    ar_d = ar_q;
    wd_d = wd_q;
    rx_d = rx_q;
    nf_d = nf_q;
    rdata_d = rdata_q;
    busy_d = busy_q;
    done_d = 1'b0;
    nack_d = nack_q;
    cnt_d = (st_q == IDLE || wrap) ? '0 : cnt_q + 16'd1;
    if (wrap) ph_d = (last || (st_q == START && ph_q[0])) ? 2'd0 : ph_q + 2'd1;
    case (st_q)
      IDLE: if (start && !done_q) begin
        st_d = START;
        ph_d = 2'd0;
        bit_d = 3'd0;
        ar_d = {addr, rw};
        wd_d = wdata;
        nf_d = 1'b0;
        nack_d = 1'b0;
        busy_d = 1'b1;
      end
      START: if (wrap && ph_q[0]) st_d = ADDR;
      ADDR: if (wrap && last) begin
        st_d = bit_q == 3'd7 ? ACK1 : ADDR;
        bit_d = bit_q + 3'd1;
      end
      ACK1: begin
        if (smp && sda_in) nf_d = 1'b1;
        if (wrap && last) st_d = nf_q ? STOP : DATA;
      end
      DATA: begin
        if (smp && ar_q[0]) rx_d = {rx_q[6:0], sda_in};
        if (wrap && last) begin
          st_d = bit_q == 3'd7 ? ACK2 : DATA;
          bit_d = bit_q + 3'd1;
        end
      end
      ACK2: begin
        if (smp && !ar_q[0] && sda_in) nf_d = 1'b1;
        if (wrap && last) st_d = STOP;
      end
      STOP: if (wrap && last) begin
        st_d = IDLE;
        busy_d = 1'b0;
        done_d = 1'b1;
        nack_d = nf_q;
        rdata_d = (ar_q[0] && !nf_q) ? rx_q : rdata_q;
      end
      default: st_d = IDLE;
    endcase
    txb = st_d == ADDR ? ar_d[~bit_d] : wd_d[~bit_d];
    sclk_d = st_d == IDLE || (st_d == START ? ph_d == 2'd0 : st_d == STOP ? ph_d != 2'd0 : ph_d == 2'd1);
    low_d = st_d == START || (st_d == STOP && ph_d != 2'd2) ||
            ((st_d == ADDR || (st_d == DATA && !ar_d[0])) && !txb);
  end
  // State and registered outputs; reset drops straight to an idle bus without a STOP
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      cnt_q <= '0;
      ph_q <= '0;
      bit_q <= '0;
      ar_q <= '0;
      wd_q <= '0;
      rx_q <= '0;
      nf_q <= 1'b0;
      rdata_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      nack_q <= 1'b0;
      sclk_q <= 1'b1;
      low_q <= 1'b0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      ph_q <= ph_d;
      bit_q <= bit_d;
      ar_q <= ar_d;
      wd_q <= wd_d;
      rx_q <= rx_d;
      nf_q <= nf_d;
      rdata_q <= rdata_d;
      busy_q <= busy_d;
      done_q <= done_d;
      nack_q <= nack_d;
      sclk_q <= sclk_d;
      low_q <= low_d;
    end
  end
endmodule
